spi_cfg_master: RTL and testbench

Sequencer that configures the SPI register peripheral over its three-wire SPI port. It accepts (write flag, address, data) commands on a valid/ready handshake and serializes each one into a 16-bit SPI mode-0 frame on `spi_sclk`/`spi_copi`/`spi_nCS`. Frame pacing meets the peripheral's synchronizer and chip-select requirements. It sits on-chip beside the peripheral, in the same clock domain, and drives its SPI inputs for self-configuration and for bench loopback.

---
 rtl/spi_cfg_master.sv | 175 +++++++++++++++++
 tb/tb_spi_cfg_master.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: serializes (write, addr, data) commands into 16-bit SPI
// mode-0 frames with programmable sclk divider and chip-select pacing.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_nCS,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;

  logic       sclk_q, sclk_d;
  logic       copi_q, copi_d;
  logic       ncs_q, ncs_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] fcnt_q, fcnt_d;

  // Next-state logic: per-state cycle counter, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid && ready_q) begin
          shreg_d = {cmd_write, cmd_addr, cmd_data};
          bit_d   = 4'd15;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[14:0], 1'b0};
          if (bit_q == 4'd0) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q - 4'd1;
            state_d = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop;
  // copi follows the shifted register, so a new bit appears exactly when sclk falls.
  always_comb begin
    ncs_d   = 1'b1;
    sclk_d  = 1'b0;
    copi_d  = 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == HOLD) && (state_d == GAP);
    fcnt_d  = fcnt_q + {7'd0, done_d};
    unique case (state_d)
      SETUP, SHIFT_LO: begin
        ncs_d  = 1'b0;
        copi_d = shreg_d[15];
      end
      SHIFT_HI: begin
        ncs_d  = 1'b0;
        sclk_d = 1'b1;
        copi_d = shreg_d[15];
      end
      HOLD: begin
        ncs_d = 1'b0;
      end
      default: begin
        ncs_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign spi_sclk    = sclk_q;
  assign spi_copi    = copi_q;
  assign spi_nCS     = ncs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Testbench for spi_cfg_master: directed vector table plus hand-written
// sequences for reset, back-to-back, mid-frame abort and counter wrap.
module tb_spi_cfg_master;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_IDLE  = 4;
  localparam int L = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       spi_sclk, spi_copi, spi_nCS, busy, done;
  logic [7:0] frame_count;

  spi_cfg_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .spi_sclk   (spi_sclk),
    .spi_copi   (spi_copi),
    .spi_nCS    (spi_nCS),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // SPI monitor and peripheral model, sampled on the falling clk edge.
  logic [7:0]  periph [128];
  logic [15:0] mon_sh = '0;
  logic [15:0] last_frame = '0;
  int mon_bits = 0, last_bits = 0;
  int low_len = 0, last_low_len = 0, high_len = 0, last_high_len = 0;
  int done_cnt = 0, done_wide = 0, sclk_idle_err = 0, copi_err = 0;
  int last_accept = 0, prev_accept = 0, last_done = 0;
  logic p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      prev_accept = last_accept;
      last_accept = cyc + 1;
    end
    if (done) begin
      done_cnt++;
      last_done = cyc + 1;
      if (p_done) done_wide++;
    end
    if (spi_nCS && spi_sclk) sclk_idle_err++;
    if (p_sclk && spi_sclk && (spi_copi !== p_copi)) copi_err++;
    if (!spi_nCS) begin
      if (p_ncs) begin
        low_len = 0;
        last_high_len = high_len;
      end
      low_len++;
      if (spi_sclk && !p_sclk) begin
        mon_sh = {mon_sh[14:0], spi_copi};
        mon_bits++;
      end
    end else begin
      if (!p_ncs) begin
        last_low_len = low_len;
        last_frame   = mon_sh;
        last_bits    = mon_bits;
        if (mon_bits == 16 && mon_sh[15]) periph[mon_sh[14:8]] = mon_sh[7:0];
        mon_bits = 0;
        high_len = 0;
      end
      high_len++;
    end
    p_sclk = spi_sclk;
    p_ncs  = spi_nCS;
    p_copi = spi_copi;
    p_done = done;
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      settle();
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(name, ok, 1);
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    wait_ready("accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    cmd_addr  = ~a;
  endtask

  task automatic wait_done(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      settle();
      if (done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(name, ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] frame;
    logic [7:0]  reg_after;
  } vec_t;

  vec_t vt [4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_fc;
    int d0;

    for (int i = 0; i < 128; i++) periph[i] = 8'h00;

    vt[0] = '{1'b1, 7'h04, 8'h80, 16'h8480, 8'h80};
    vt[1] = '{1'b0, 7'h01, 8'h55, 16'h0155, 8'h00};
    vt[2] = '{1'b1, 7'h7F, 8'hA5, 16'hFFA5, 8'hA5};
    vt[3] = '{1'b0, 7'h04, 8'h11, 16'h0411, 8'h80};

    // Reset held 3 cycles while a command is offered.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 7'h7F;
    cmd_data  = 8'hFF;
    repeat (3) settle();
    check("rst_ncs", spi_nCS, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_copi", spi_copi, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fcnt", frame_count, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    settle();
    check("ready_before_sample", cmd_ready, 0);
    settle();
    check("ready_after_release", cmd_ready, 1);

    // Directed single frames.
    exp_fc = 0;
    for (int i = 0; i < 4; i++) begin
      send(vt[i].w, vt[i].a, vt[i].d);
      wait_done("done_timeout");
      exp_fc = (exp_fc + 1) % 256;
      check($sformatf("v%0d_frame", i), last_frame, vt[i].frame);
      check($sformatf("v%0d_bits", i), last_bits, 16);
      check($sformatf("v%0d_ncs_low", i), last_low_len, L);
      check($sformatf("v%0d_done_lat", i), last_done - last_accept, L + 1);
      check($sformatf("v%0d_fcnt", i), frame_count, exp_fc);
      check($sformatf("v%0d_reg", i), periph[vt[i].a], vt[i].reg_after);
    end

    // Back-to-back with cmd_valid held across both accepts.
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 7'h00;
    cmd_data  = 8'hFF;
    wait_ready("b2b_accept1");
    @(posedge clk);
    #1;
    cmd_addr = 7'h02;
    cmd_data = 8'h0F;
    wait_ready("b2b_accept2");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done("b2b_done");
    exp_fc = exp_fc + 2;
    check("b2b_period", last_accept - prev_accept, L + CS_IDLE + 1);
    // nCS stays high for the GAP cycles plus the IDLE cycle that accepts.
    check("b2b_ncs_high", last_high_len, CS_IDLE + 1);
    check("b2b_reg0", periph[0], 8'hFF);
    check("b2b_reg2", periph[2], 8'h0F);
    check("b2b_fcnt", frame_count, exp_fc);

    // Reset after the 8th rising sclk edge of a frame.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 7'h03;
    cmd_data  = 8'h33;
    wait_ready("abort_accept");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    begin
      int ok;
      ok = 0;
      for (int i = 0; i < 500; i++) begin
        settle();
        if (mon_bits == 8) begin
          ok = 1;
          break;
        end
      end
      if (!ok) check("abort_bit8_timeout", ok, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ncs", spi_nCS, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_copi", spi_copi, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 0);
    check("abort_fcnt", frame_count, 0);
    rst_n = 1'b1;
    repeat (4) settle();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_write", periph[3], 8'h00);
    send(1'b1, 7'h05, 8'h5A);
    wait_done("after_abort_done");
    check("after_abort_frame", last_frame, 16'h855A);
    check("after_abort_fcnt", frame_count, 1);
    check("after_abort_reg", periph[5], 8'h5A);

    // 257 frames from a fresh reset: counter wraps 255 -> 0 -> 1.
    do_reset();
    d0 = done_cnt;
    for (int i = 0; i < 257; i++) begin
      send(1'b1, 7'(i % 128), 8'(i));
      wait_done("wrap_done");
      check($sformatf("wrap_fcnt%0d", i), frame_count, (i + 1) % 256);
    end
    check("wrap_done_count", done_cnt - d0, 257);
    check("done_width", done_wide, 0);
    check("sclk_while_ncs_high", sclk_idle_err, 0);
    check("copi_change_sclk_high", copi_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
